pipe_run_ctrl: RTL and testbench

//  Run/halt controller clocked directly by the free-running testbench clock; gates
//  the pipeline. Drives a global stage enable (pipe_en) and a fetch hold (if_hold).

---
 rtl/mips_dbg_pkg.sv | 27 ++
 rtl/pipe_perf_cnt.sv | 25 ++
 rtl/pipe_run_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_run_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared encodings for the pipeline run/halt debug controller:
// host command opcodes, controller states and halt-cause codes.
package mips_dbg_pkg;

    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_HALT  = 2'd1,
        OP_STEP  = 2'd2,
        OP_RUN_N = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_RUN   = 2'd1,
        S_RUNN  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_RESET = 3'd0,
        CAUSE_HOST  = 3'd1,
        CAUSE_BP    = 3'd2,
        CAUSE_INSTR = 3'd3,
        CAUSE_COUNT = 3'd4
    } cause_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Free-running performance counters: enabled cycles and retired instructions.
// Both wrap modulo 2^CNT_W; only reset clears them.
module pipe_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             retire_valid,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else if (en) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire_valid)
                retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run/halt controller: gates the pipeline via pipe_en/if_hold from host commands,
// PC breakpoint, HALT-instruction drain and RUN_N cycle budget.
module pipe_run_ctrl
    import mips_dbg_pkg::*;
#(
    parameter int PC_W         = 32,
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 4,
    parameter int AUTO_RUN     = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             halt_instr,
    input  logic             retire_valid,
    output logic             pipe_en,
    output logic             if_hold,
    output logic             halted,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int     DW        = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
    localparam state_e RST_STATE = (AUTO_RUN != 0) ? S_RUN : S_HALT;

    state_e           state, state_n;
    cause_e           cause, cause_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic [DW-1:0]    drain_cnt, drain_n;
    logic             bp_skip, bp_skip_n;
    logic             cmd_acc, bp_hit, running;

    assign cmd_ready  = (state != S_DRAIN);
    assign cmd_acc    = cmd_valid && cmd_ready;
    assign running    = (state == S_RUN) || (state == S_RUNN);
    assign bp_hit     = bp_en && (if_pc == bp_addr) && !bp_skip;
    assign halted     = (state == S_HALT);
    assign halt_cause = cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST_STATE;
            cause     <= CAUSE_RESET;
            remaining <= '0;
            drain_cnt <= '0;
            bp_skip   <= 1'b0;
            pipe_en   <= (AUTO_RUN != 0);
            if_hold   <= 1'b0;
        end else begin
            state     <= state_n;
            cause     <= cause_n;
            remaining <= remaining_n;
            drain_cnt <= drain_n;
            bp_skip   <= bp_skip_n;
            pipe_en   <= (state_n != S_HALT);
            if_hold   <= (state_n == S_DRAIN);
        end
    end

    always_comb begin
        state_n     = state;
        cause_n     = cause;
        remaining_n = remaining;
        drain_n     = drain_cnt;
        // The skip only has to survive until the pipeline has moved once.
        bp_skip_n   = (state == S_HALT) ? bp_skip : 1'b0;
        case (state)
            S_HALT: begin
                if (cmd_acc) begin
                    case (cmd_op_e'(cmd_op))
                        OP_RUN:  state_n = S_RUN;
                        OP_STEP: begin
                            state_n     = S_RUNN;
                            remaining_n = CNT_W'(1);
                        end
                        OP_RUN_N: begin
                            if (cmd_arg != '0) begin
                                state_n     = S_RUNN;
                                remaining_n = cmd_arg;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN, S_RUNN: begin
                if (state == S_RUNN)
                    remaining_n = remaining - CNT_W'(1);
                // Priority: host HALT > halt_instr > breakpoint > count expiry.
                if (cmd_acc && (cmd_op_e'(cmd_op) == OP_HALT)) begin
                    state_n = S_HALT;
                    cause_n = CAUSE_HOST;
                end else if (halt_instr) begin
                    state_n = S_DRAIN;
                    drain_n = DW'(DRAIN_CYCLES);
                end else if (bp_hit) begin
                    state_n   = S_HALT;
                    cause_n   = CAUSE_BP;
                    bp_skip_n = 1'b1;
                end else if ((state == S_RUNN) && (remaining == CNT_W'(1))) begin
                    state_n = S_HALT;
                    cause_n = CAUSE_COUNT;
                end
            end
            S_DRAIN: begin
                drain_n = drain_cnt - DW'(1);
                if (drain_cnt <= DW'(1)) begin
                    state_n = S_HALT;
                    cause_n = CAUSE_INSTR;
                end
            end
            default: state_n = S_HALT;
        endcase
    end

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (pipe_en),
        .retire_valid (retire_valid),
        .cycle_cnt    (cycle_cnt),
        .retire_cnt   (retire_cnt)
    );

    logic unused_running;
    assign unused_running = running;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Scoreboarded bench for pipe_run_ctrl: expected results are queued as stimulus
// is issued and popped against DUT observations.
module tb_pipe_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_arg;
    logic        bp_en;
    logic [31:0] bp_addr, if_pc;
    logic        halt_instr, retire_valid;
    logic        pipe_en, if_hold, halted;
    logic [2:0]  halt_cause;
    logic [31:0] cycle_cnt, retire_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    pipe_run_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .bp_en(bp_en), .bp_addr(bp_addr),
        .if_pc(if_pc), .halt_instr(halt_instr), .retire_valid(retire_valid),
        .pipe_en(pipe_en), .if_hold(if_hold), .halted(halted), .halt_cause(halt_cause),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic push(input string tag, input logic [63:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [63:0] act);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            chk(e.tag, act, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic count_en(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            if (pipe_en) n++;
            tick();
        end
    endtask

    initial begin
        int n, nh;
        logic rdy_bad;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = '0;
        bp_en = 1'b0; bp_addr = '0; if_pc = '0; halt_instr = 1'b0; retire_valid = 1'b0;
        #12;
        push("rst_halted", 1); push("rst_pipe_en", 0); push("rst_cause", 0);
        push("rst_cycle", 0); push("rst_ready", 1);
        pop_chk(halted); pop_chk(pipe_en); pop_chk(halt_cause);
        pop_chk(cycle_cnt); pop_chk(cmd_ready);
        tick();
        rst_n = 1'b1;
        tick();

        // RUN_N 5 with a retire every enabled cycle
        retire_valid = 1'b1;
        push("runn_pulses", 5); push("runn_halted", 1); push("runn_cause", 4);
        push("runn_cycle", 5); push("runn_retire", 5);
        send_cmd(2'd3, 32'd5);
        count_en(12, n);
        pop_chk(n); pop_chk(halted); pop_chk(halt_cause);
        pop_chk(cycle_cnt); pop_chk(retire_cnt);
        retire_valid = 1'b0;

        // RUN_N 0 is accepted and ignored
        push("runn0_halted", 1); push("runn0_cycle", 5);
        send_cmd(2'd3, 32'd0);
        tick(); tick();
        pop_chk(halted); pop_chk(cycle_cnt);

        // Three single steps
        for (int s = 0; s < 3; s++) begin
            push("step_pulses", 1); push("step_cause", 4);
            send_cmd(2'd2, 32'd0);
            count_en(5, n);
            pop_chk(n); pop_chk(halt_cause);
        end
        push("step_cycle", 8); push("step_retire", 5);
        pop_chk(cycle_cnt); pop_chk(retire_cnt);

        // Breakpoint at 0x40, then resume without re-trap
        bp_en = 1'b1; bp_addr = 32'h40; if_pc = 32'h38;
        send_cmd(2'd0, 32'd0);
        if_pc = 32'h3c;
        tick();
        push("bp_pre_run", 1);
        pop_chk(pipe_en);
        if_pc = 32'h40;
        tick();
        push("bp_pipe_en", 0); push("bp_cause", 2);
        pop_chk(pipe_en); pop_chk(halt_cause);
        send_cmd(2'd0, 32'd0);
        tick();
        if_pc = 32'h44;
        tick(); tick();
        push("bp_resume_en", 1); push("bp_resume_halted", 0);
        pop_chk(pipe_en); pop_chk(halted);
        push("host_halted", 1); push("host_cause", 1);
        send_cmd(2'd1, 32'd0);
        pop_chk(halted); pop_chk(halt_cause);
        bp_en = 1'b0;

        // HALT instruction drain
        send_cmd(2'd0, 32'd0);
        halt_instr = 1'b1;
        tick();
        halt_instr = 1'b0;
        nh = 0; rdy_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (if_hold && pipe_en) nh++;
            if (if_hold && cmd_ready) rdy_bad = 1'b1;
            tick();
        end
        push("drain_cycles", 4); push("drain_ready_low", 0);
        push("drain_halted", 1); push("drain_cause", 3);
        pop_chk(nh); pop_chk(rdy_bad); pop_chk(halted); pop_chk(halt_cause);

        // Host HALT beats halt_instr in the same cycle
        send_cmd(2'd0, 32'd0);
        halt_instr = 1'b1;
        send_cmd(2'd1, 32'd0);
        halt_instr = 1'b0;
        push("prio_halted", 1); push("prio_hold", 0); push("prio_cause", 1);
        pop_chk(halted); pop_chk(if_hold); pop_chk(halt_cause);

        // Async reset in the middle of a drain
        send_cmd(2'd0, 32'd0);
        halt_instr = 1'b1;
        tick();
        halt_instr = 1'b0;
        tick();
        push("mid_drain_hold", 1);
        pop_chk(if_hold);
        #2 rst_n = 1'b0;
        #1;
        push("arst_hold", 0); push("arst_pipe_en", 0); push("arst_halted", 1);
        push("arst_cause", 0); push("arst_cycle", 0); push("arst_retire", 0);
        pop_chk(if_hold); pop_chk(pipe_en); pop_chk(halted);
        pop_chk(halt_cause); pop_chk(cycle_cnt); pop_chk(retire_cnt);
        tick();
        rst_n = 1'b1;
        tick();

        if (exp_q.size() != 0) chk("sb_leftover", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
